// File: rtl/mapper_trap_ctrl.sv
// mapper_trap_ctrl: oversampled Z80 I/O mapper. It holds the bank registers,
// queues trapped I/O violations in a FIFO and sequences NMI delivery.
module mapper_trap_ctrl #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_W     = 8,
    parameter int unsigned TRAP_DEPTH = 4,
    parameter int unsigned NMI_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   data_in,
    output logic [7:0]                   data_out,
    output logic                         data_oe,
    input  logic                         wr_n,
    input  logic                         rd_n,
    input  logic                         iorq_n,
    input  logic                         m1_n,
    input  logic [7:0]                   io_addr,
    input  logic                         io_enable,
    input  logic                         irq_sys_n,
    input  logic [$clog2(NUM_BANKS)-1:0] page,
    output logic                         iorq_sys_n,
    output logic                         irq_n,
    output logic                         nmi_n,
    output logic [BANK_W-1:0]            bank_out
);

    localparam int unsigned IW  = $clog2(NUM_BANKS);
    localparam int unsigned PW  = $clog2(TRAP_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned PCW = $clog2(NMI_CYCLES + 1);

    typedef enum logic [1:0] {N_IDLE, N_PULSE, N_WAIT} nmi_state_t;

    // sample stage (s_*) and previous-sample stage (p_*)
    logic       s_wr_n, s_rd_n, s_iorq_n, s_m1_n, s_io_enable, s_irq_sys_n;
    logic [7:0] s_io_addr, s_data_in;
    logic       p_wr_n, p_rd_n, p_iorq_n, p_m1_n, p_hit;
    logic [2:0] p_addr;
    logic [7:0] p_data_in;
    logic [1:0] warm;

    logic [3:0]        ctrl_q;
    logic [IW-1:0]     bank_index;
    logic [BANK_W-1:0] banks [NUM_BANKS];

    logic       v_act, v_dir, v_got;
    logic [7:0] v_port, v_data;

    logic [7:0] f_port [TRAP_DEPTH];
    logic [7:0] f_data [TRAP_DEPTH];
    logic       f_dir  [TRAP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    nmi_state_t state, next_state;
    logic [PCW-1:0] pcnt;
    logic nmi_n_d, nmi_busy;

    logic virtual_enable, nmi_enable, irq_intercept, force_irq;
    logic s_hit, ev_ok, io_start, io_end, p_map, reg_wr, pop_req, rd_active;
    logic push_req, do_push, do_pop, full, empty, ovf_set, clr_ovf;
    logic [7:0] rd_mux;

    assign virtual_enable = ctrl_q[0];
    assign nmi_enable     = ctrl_q[1];
    assign irq_intercept  = ctrl_q[2];
    assign force_irq      = ctrl_q[3];

    // forwarded I/O request is the only combinational output
    assign iorq_sys_n = iorq_n | (m1_n & ((io_enable & (io_addr[7:3] == 5'd0)) | virtual_enable));

    // event decode on sampled bus; blocked until both sample stages hold post-reset data
    always_comb begin
        s_hit     = s_io_enable && (s_io_addr[7:3] == 5'd0);
        ev_ok     = warm[1];
        io_start  = ev_ok && p_iorq_n && !s_iorq_n && s_m1_n;
        io_end    = ev_ok && !p_iorq_n && s_iorq_n;
        p_map     = ev_ok && !p_iorq_n && p_m1_n && p_hit;
        reg_wr    = p_map && !p_wr_n && s_wr_n;
        pop_req   = p_map && !p_rd_n && s_rd_n && (p_addr == 3'd6);
        rd_active = ev_ok && !s_iorq_n && s_m1_n && s_hit && !s_rd_n;
        clr_ovf   = reg_wr && (p_addr == 3'd1) && p_data_in[7];
        push_req  = io_end && v_act;
        full      = (count == CW'(TRAP_DEPTH));
        empty     = (count == '0);
        do_pop    = pop_req && !empty;
        do_push   = push_req && (!full || do_pop);
        ovf_set   = push_req && full && !do_pop;
    end

    // bus sampling; inactive level is 1
    always_ff @(posedge clk) begin
        if (reset) begin
            s_wr_n <= 1'b1; s_rd_n <= 1'b1; s_iorq_n <= 1'b1; s_m1_n <= 1'b1;
            s_io_enable <= 1'b0; s_irq_sys_n <= 1'b1;
            s_io_addr <= 8'hFF; s_data_in <= 8'hFF;
            p_wr_n <= 1'b1; p_rd_n <= 1'b1; p_iorq_n <= 1'b1; p_m1_n <= 1'b1;
            p_hit <= 1'b0; p_addr <= 3'd7; p_data_in <= 8'hFF;
            warm <= 2'b00;
        end else begin
            s_wr_n <= wr_n; s_rd_n <= rd_n; s_iorq_n <= iorq_n; s_m1_n <= m1_n;
            s_io_enable <= io_enable; s_irq_sys_n <= irq_sys_n;
            s_io_addr <= io_addr; s_data_in <= data_in;
            p_wr_n <= s_wr_n; p_rd_n <= s_rd_n; p_iorq_n <= s_iorq_n; p_m1_n <= s_m1_n;
            p_hit <= s_hit; p_addr <= s_io_addr[2:0]; p_data_in <= s_data_in;
            warm <= {warm[0], 1'b1};
        end
    end

    // mapper register writes commit on the write strobe rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 4'd0;
            bank_index <= '0;
            for (int i = 0; i < NUM_BANKS; i++) banks[i] <= '0;
        end else if (reg_wr) begin
            case (p_addr)
                3'd1: ctrl_q <= p_data_in[3:0];
                3'd2: bank_index <= p_data_in[IW-1:0];
                3'd3: banks[bank_index] <= p_data_in[BANK_W-1:0];
                default: ;
            endcase
        end
    end

    // violation capture: port and direction at start, first written data byte
    always_ff @(posedge clk) begin
        if (reset) begin
            v_act <= 1'b0; v_dir <= 1'b0; v_got <= 1'b0;
            v_port <= 8'hFF; v_data <= 8'hFF;
        end else begin
            if (io_start) begin
                v_act  <= virtual_enable && !s_hit;
                v_port <= s_io_addr;
                v_dir  <= !s_wr_n;
                v_got  <= !s_wr_n;
                v_data <= !s_wr_n ? s_data_in : 8'hFF;
            end else if (v_act && !s_wr_n && !v_got) begin
                v_dir  <= 1'b1;
                v_got  <= 1'b1;
                v_data <= s_data_in;
            end
            if (io_end) v_act <= 1'b0;
        end
    end

    // trap FIFO storage
    always_ff @(posedge clk) begin
        if (do_push) begin
            f_port[wr_ptr] <= v_port;
            f_data[wr_ptr] <= v_data;
            f_dir[wr_ptr]  <= v_dir;
        end
    end

    // trap FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // NMI state register and pulse counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= N_IDLE;
            pcnt  <= '0;
        end else begin
            state <= next_state;
            pcnt  <= (state == N_PULSE) ? pcnt + PCW'(1) : '0;
        end
    end

    // NMI next-state logic
    always_comb begin
        next_state = state;
        case (state)
            N_IDLE:  if (nmi_enable && (do_push || !empty)) next_state = N_PULSE;
            N_PULSE: if (pcnt == PCW'(NMI_CYCLES - 1)) next_state = N_WAIT;
            N_WAIT:  if (empty) next_state = N_IDLE;
            default: next_state = N_IDLE;
        endcase
    end

    // NMI outputs; nmi_n is registered from the next state so it aligns with N_PULSE
    always_comb begin
        nmi_n_d  = (next_state != N_PULSE);
        nmi_busy = (state != N_IDLE);
    end

    // register read multiplexer
    always_comb begin
        rd_mux = 8'hFF;
        case (s_io_addr[2:0])
            3'd0: rd_mux = {overflow, nmi_busy, empty, full, 4'(count)};
            3'd1: rd_mux = {4'd0, ctrl_q};
            3'd2: rd_mux = 8'(bank_index);
            3'd3: rd_mux = 8'(banks[bank_index]);
            3'd4: rd_mux = empty ? 8'hFF : f_port[rd_ptr];
            3'd5: rd_mux = empty ? 8'hFF : {7'd0, f_dir[rd_ptr]};
            3'd6: rd_mux = empty ? 8'hFF : f_data[rd_ptr];
            default: rd_mux = 8'hFF;
        endcase
    end

    // registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            data_oe  <= 1'b0;
            data_out <= 8'hFF;
            nmi_n    <= 1'b1;
            irq_n    <= 1'b1;
            bank_out <= '0;
        end else begin
            data_oe  <= rd_active;
            data_out <= rd_active ? rd_mux : 8'hFF;
            nmi_n    <= nmi_n_d;
            irq_n    <= irq_intercept ? !force_irq : s_irq_sys_n;
            bank_out <= banks[page];
        end
    end

endmodule

// File: tb/tb_mapper_trap_ctrl.sv
// tb_mapper_trap_ctrl: register-map table, trap FIFO, NMI and reset sequences.
module tb_mapper_trap_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in, data_out, io_addr;
    logic       data_oe, wr_n, rd_n, iorq_n, m1_n, io_enable, irq_sys_n;
    logic [1:0] page;
    logic       iorq_sys_n, irq_n, nmi_n;
    logic [7:0] bank_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    int pulse_cnt = 0, last_len = 0, cur_len = 0;
    logic oe_prev = 1'b0;

    typedef struct {
        logic [7:0] addr;
        bit         wr;
        logic [7:0] data;
        string      name;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    mapper_trap_ctrl dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .wr_n(wr_n), .rd_n(rd_n), .iorq_n(iorq_n), .m1_n(m1_n),
        .io_addr(io_addr), .io_enable(io_enable), .irq_sys_n(irq_sys_n), .page(page),
        .iorq_sys_n(iorq_sys_n), .irq_n(irq_n), .nmi_n(nmi_n), .bank_out(bank_out)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // scoreboard consumer: compare each read as data_oe asserts
    always @(negedge clk) begin
        if (data_oe === 1'b1 && oe_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_oe actual=%h required=none", data_out);
            end else begin
                check8(name_q.pop_front(), data_out, exp_q.pop_front());
            end
        end
        oe_prev = data_oe;
    end

    // NMI pulse monitor
    always @(negedge clk) begin
        if (nmi_n === 1'b0) cur_len++;
        else if (cur_len != 0) begin
            last_len = cur_len;
            pulse_cnt++;
            cur_len = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic bus(input logic [7:0] a, input bit wr, input logic [7:0] d, output logic sys_n);
        @(negedge clk);
        io_addr = a;
        data_in = wr ? d : 8'hFF;
        iorq_n  = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        #1 sys_n = iorq_sys_n;
        repeat (4) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; data_in = 8'hFF;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic s;
        bus(a, 1'b1, d, s);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        logic s;
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus(a, 1'b0, 8'h00, s);
        checki({name, "_oe"}, exp_q.size(), 0);
        exp_q.delete();
        name_q.delete();
    endtask

    initial begin
        logic s;
        int p0;

        reset = 1'b1; data_in = 8'hFF; io_addr = 8'hFF; wr_n = 1'b1; rd_n = 1'b1;
        iorq_n = 1'b1; m1_n = 1'b1; io_enable = 1'b1; irq_sys_n = 1'b1; page = 2'd0;

        tbl[0]  = '{8'h00, 1'b0, 8'h20, "st_reset"};
        tbl[1]  = '{8'h01, 1'b0, 8'h00, "ctrl_reset"};
        tbl[2]  = '{8'h03, 1'b0, 8'h00, "bank0_reset"};
        tbl[3]  = '{8'h04, 1'b0, 8'hFF, "port_empty"};
        tbl[4]  = '{8'h05, 1'b0, 8'hFF, "dir_empty"};
        tbl[5]  = '{8'h06, 1'b0, 8'hFF, "data_empty"};
        tbl[6]  = '{8'h07, 1'b0, 8'hFF, "reserved"};
        tbl[7]  = '{8'h01, 1'b1, 8'h86, ""};
        tbl[8]  = '{8'h01, 1'b0, 8'h06, "ctrl_rb"};
        tbl[9]  = '{8'h01, 1'b1, 8'h00, ""};
        tbl[10] = '{8'h02, 1'b1, 8'h02, ""};
        tbl[11] = '{8'h03, 1'b1, 8'h5A, ""};
        tbl[12] = '{8'h02, 1'b1, 8'h01, ""};
        tbl[13] = '{8'h03, 1'b1, 8'h33, ""};
        tbl[14] = '{8'h03, 1'b0, 8'h33, "bank1"};
        tbl[15] = '{8'h02, 1'b1, 8'h02, ""};
        tbl[16] = '{8'h02, 1'b0, 8'h02, "bank_idx"};
        tbl[17] = '{8'h03, 1'b0, 8'h5A, "bank2"};
        tbl[18] = '{8'h00, 1'b0, 8'h20, "st_after"};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check8("nmi_reset", {7'd0, nmi_n}, 8'h01);
        check8("oe_reset", {7'd0, data_oe}, 8'h00);
        check8("dout_reset", data_out, 8'hFF);
        check8("bank_out_reset", bank_out, 8'h00);
        irq_sys_n = 1'b0;
        repeat (3) @(negedge clk);
        check8("irq_pass_lo", {7'd0, irq_n}, 8'h00);
        irq_sys_n = 1'b1;
        repeat (3) @(negedge clk);
        check8("irq_pass_hi", {7'd0, irq_n}, 8'h01);

        // register map table
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else           rd(tbl[i].addr, tbl[i].data, tbl[i].name);
        end

        // bank_out follows page one clk later
        page = 2'd2; @(negedge clk); check8("bank_out_p2", bank_out, 8'h5A);
        page = 2'd1; @(negedge clk); check8("bank_out_p1", bank_out, 8'h33);
        page = 2'd0; @(negedge clk); check8("bank_out_p0", bank_out, 8'h00);

        // non-mapper I/O without virtualisation passes through and is not trapped
        bus(8'h80, 1'b1, 8'h42, s);
        check8("sys_pass", {7'd0, s}, 8'h00);
        rd(8'h00, 8'h20, "st_no_trap");

        // single trapped OUT and NMI pulse
        wr(8'h01, 8'h03);
        p0 = pulse_cnt;
        bus(8'h80, 1'b1, 8'h42, s);
        check8("sys_block", {7'd0, s}, 8'h01);
        repeat (12) @(negedge clk);
        checki("pulse_cnt1", pulse_cnt - p0, 1);
        checki("pulse_len", last_len, 8);
        rd(8'h00, 8'h41, "st_wait");
        rd(8'h04, 8'h80, "trap_port");
        rd(8'h05, 8'h01, "trap_dir");
        rd(8'h06, 8'h42, "trap_data");
        rd(8'h00, 8'h20, "st_idle");

        // five trapped INs into a four-entry FIFO
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) bus(8'h90 + 8'(i), 1'b0, 8'h00, s);
        repeat (12) @(negedge clk);
        rd(8'h00, 8'hD4, "st_ovf");
        checki("pulse_cnt_multi", pulse_cnt - p0, 1);
        for (int i = 0; i < 4; i++) begin
            rd(8'h04, 8'h90 + 8'(i), $sformatf("drain_port%0d", i));
            rd(8'h05, 8'h00, $sformatf("drain_dir%0d", i));
            rd(8'h06, 8'hFF, $sformatf("drain_data%0d", i));
        end
        rd(8'h00, 8'hA0, "st_drained");
        checki("pulse_cnt_drain", pulse_cnt - p0, 1);
        wr(8'h01, 8'h83);
        rd(8'h00, 8'h20, "st_ovf_clr");
        rd(8'h01, 8'h03, "ctrl_rb_b7");

        // push and pop in the same clk with two entries queued
        wr(8'h01, 8'h01);
        wr(8'hA1, 8'h11);
        wr(8'hA2, 8'h22);
        rd(8'h00, 8'h02, "st_two");
        exp_q.push_back(8'h11);
        name_q.push_back("pp_head");
        @(negedge clk);
        io_addr = 8'hA3; data_in = 8'hFF; iorq_n = 1'b0; rd_n = 1'b0;
        repeat (2) @(negedge clk);
        io_addr = 8'h06;
        repeat (3) @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1;
        repeat (3) @(negedge clk);
        checki("pp_oe", exp_q.size(), 0);
        exp_q.delete();
        name_q.delete();
        rd(8'h00, 8'h02, "st_pp");
        rd(8'h04, 8'hA2, "pp_port_b");
        rd(8'h06, 8'h22, "pp_data_b");
        rd(8'h04, 8'hA3, "pp_port_c");
        rd(8'h05, 8'h00, "pp_dir_c");
        rd(8'h06, 8'hFF, "pp_data_c");
        rd(8'h00, 8'h20, "st_pp_empty");

        // irq interception
        irq_sys_n = 1'b1;
        wr(8'h01, 8'h0C);
        check8("irq_force", {7'd0, irq_n}, 8'h00);
        wr(8'h01, 8'h04);
        check8("irq_unforce", {7'd0, irq_n}, 8'h01);
        irq_sys_n = 1'b0;
        repeat (3) @(negedge clk);
        check8("irq_mask", {7'd0, irq_n}, 8'h01);
        wr(8'h01, 8'h00);
        check8("irq_follow", {7'd0, irq_n}, 8'h00);
        irq_sys_n = 1'b1;

        // reset during a trapped OUT
        wr(8'h01, 8'h01);
        page = 2'd2;
        @(negedge clk);
        io_addr = 8'h80; data_in = 8'h55; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; data_in = 8'hFF;
        repeat (4) @(negedge clk);
        rd(8'h00, 8'h20, "st_rst_mid");
        rd(8'h01, 8'h00, "ctrl_rst_mid");
        rd(8'h04, 8'hFF, "port_rst_mid");
        check8("bank_out_rst", bank_out, 8'h00);
        check8("nmi_rst_mid", {7'd0, nmi_n}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
